my_alu: RTL and testbench
=========================

# my_alu

Registered Hack-style ALU. It computes one of the canonical two-operand functions of `x` and `y`, selected by six control bits, and reports zero and negative status flags. It sits in the CPU execute stage, and its result is captured one clock after the operands are presented.

## Interface
Parameters:
- `WIDTH`, default 16: operand and result width in bits; must be at least 2.

Ports:
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `in_valid`  in  1: the operands and controls on this cycle are to be captured.
- `x`  in  WIDTH: operand X, two's complement.
- `y`  in  WIDTH: operand Y, two's complement.
- `zx`  in  1: zero X.
- `nx`  in  1: invert X, applied after `zx`.
- `zy`  in  1: zero Y.
- `ny`  in  1: invert Y, applied after `zy`.
- `f`  in  1: function select; 1 = add, 0 = bitwise AND.
- `no`  in  1: invert the function result.
- `out`  out  WIDTH: registered result.
- `zr`  out  1: registered flag, 1 when `out` is all zeros.
- `ng`  out  1: registered flag, equal to `out[WIDTH-1]`.
- `out_valid`  out  1: `out`, `zr` and `ng` hold a newly captured result.
- `ov`  out  1: present only under `MY_ALU_OVERFLOW_EN` (see Configuration).

## Operation
The result is computed in this strict order:
- xa = zx ? 0 : x
- xb = nx ? ~xa : xa
- ya = zy ? 0 : y
- yb = ny ? ~ya : ya
- r = f ? (xb + yb) mod 2^WIDTH : (xb & yb)
- res = no ? ~r : r

Arithmetic and flag rules:
- The add discards the carry out; there is no carry input.
- zr = (res == 0).
- ng = res[WIDTH-1].
- `zr` and `ng` are never both 1.

Canonical encodings, written as zx nx zy ny f no:
- 0 = 101010
- 1 = 111111
- -1 = 111010
- x = 001100
- y = 110000
- !x = 001101
- !y = 110001
- -x = 001111
- -y = 110011
- x+1 = 011111
- y+1 = 110111
- x-1 = 001110
- y-1 = 110010
- x+y = 000010
- x-y = 010011
- y-x = 000111
- x&y = 000000
- x|y = 010101

Any of the 64 control combinations is legal; each one is evaluated per the formula above.

## Timing
- Latency is 1 cycle. When `in_valid`=1 at rising edge N, the result for that cycle's inputs appears on `out`/`zr`/`ng`, and `out_valid`=1, after edge N.
- When `in_valid`=0 at an edge, `out`, `zr`, `ng` and `ov` hold their previous values and `out_valid` becomes 0.
- There is no backpressure. A new operation can be issued every cycle, giving throughput of 1 per clock.
- Reset values while `rst_n`=0, taking effect immediately (asynchronous): `out`=0, `zr`=1, `ng`=0, `out_valid`=0, `ov`=0.
- An operation in flight when reset asserts is discarded.
- The first edge after `rst_n` deasserts may capture an operation.
- Inputs may change arbitrarily between edges; only the values at the rising edge matter.

## Configuration
- `MY_ALU_OVERFLOW_EN` defined: the `ov` port exists.
  - `ov` is registered alongside `out`.
  - When `f`=1, `ov` is the signed overflow of the internal add xb+yb: both addends have the same sign and the sum's sign differs.
  - When `f`=0, `ov`=0.
  - `no` does not affect `ov`.
- `MY_ALU_OVERFLOW_EN` undefined: the `ov` port and its register are absent, and all other behaviour is identical.

## Structure
- Package `my_alu_pkg` holds:
  - the `WIDTH` default constant (16);
  - the packed struct typedef `alu_ctrl_t` with fields {zx, nx, zy, ny, f, no};
  - named `alu_ctrl_t` constants for the 18 canonical functions listed above.
- Sub-module `my_alu_comb` is the purely combinational datapath: it maps x, y and ctrl to res, zr, ng and (when enabled) ov.
- `my_alu` wraps `my_alu_comb` with the valid/hold output registers and the asynchronous reset.

## Test plan
1. Reset: assert `rst_n`=0 mid-operation -> outputs immediately show out=0x0000, zr=1, ng=0, out_valid=0.
2. Constants, with x=0xAAAA, y=0xF0F0:
   - ctrl 101010 -> out 0x0000, zr=1;
   - ctrl 111111 -> out 0x0001, zr=0, ng=0;
   - ctrl 111010 -> out 0xFFFF, ng=1.
   Each result appears exactly 1 cycle after issue.
3. Arithmetic, with x=0xAAAA, y=0xF0F0:
   - x+y -> 0x9B9A, ng=1;
   - x-y -> 0xB9BA;
   - y-x -> 0x4646, ng=0;
   - -x -> 0x5556;
   - x-1 -> 0xAAA9;
   - y+1 -> 0xF0F1.
4. Logic and wrap:
   - x&y on 0xAAAA/0xF0F0 -> 0xA0A0;
   - x|y -> 0xFAFA, ng=1;
   - !x with x=0xFFFF -> 0x0000, zr=1;
   - x+1 with x=0xFFFF -> 0x0000, zr=1, ng=0.
5. Hold and back-to-back:
   - issue 3 operations on consecutive cycles -> 3 consecutive results with out_valid=1;
   - then `in_valid`=0 with the inputs changing -> out/zr/ng hold, out_valid=0.
6. With `MY_ALU_OVERFLOW_EN`:
   - x+y on 0x7FFF/0x0001 -> out 0x8000, ov=1;
   - x+y on 0xAAAA/0xF0F0 -> ov=0;
   - x&y -> ov=0.

Source files
------------

// File: rtl/my_alu_pkg.sv
// my_alu_pkg
// Shared definitions for the Hack-style ALU:
//   ALU_WIDTH  - default operand/result width (16)
//   alu_ctrl_t - packed control word {zx, nx, zy, ny, f, no}
//   CTRL_*     - the 18 canonical function encodings
package my_alu_pkg;

  localparam int unsigned ALU_WIDTH = 16;

  // Field order matches the "zx nx zy ny f no" notation, so a 6-bit literal
  // written in that order maps directly onto the struct.
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  localparam alu_ctrl_t CTRL_ZERO    = 6'b101010;
  localparam alu_ctrl_t CTRL_ONE     = 6'b111111;
  localparam alu_ctrl_t CTRL_NEG_ONE = 6'b111010;
  localparam alu_ctrl_t CTRL_X       = 6'b001100;
  localparam alu_ctrl_t CTRL_Y       = 6'b110000;
  localparam alu_ctrl_t CTRL_NOT_X   = 6'b001101;
  localparam alu_ctrl_t CTRL_NOT_Y   = 6'b110001;
  localparam alu_ctrl_t CTRL_NEG_X   = 6'b001111;
  localparam alu_ctrl_t CTRL_NEG_Y   = 6'b110011;
  localparam alu_ctrl_t CTRL_X_INC   = 6'b011111;
  localparam alu_ctrl_t CTRL_Y_INC   = 6'b110111;
  localparam alu_ctrl_t CTRL_X_DEC   = 6'b001110;
  localparam alu_ctrl_t CTRL_Y_DEC   = 6'b110010;
  localparam alu_ctrl_t CTRL_X_ADD_Y = 6'b000010;
  localparam alu_ctrl_t CTRL_X_SUB_Y = 6'b010011;
  localparam alu_ctrl_t CTRL_Y_SUB_X = 6'b000111;
  localparam alu_ctrl_t CTRL_X_AND_Y = 6'b000000;
  localparam alu_ctrl_t CTRL_X_OR_Y  = 6'b010101;

endpackage

// File: rtl/my_alu_comb.sv
// my_alu_comb
// Purely combinational Hack ALU datapath.
// Ports:
//   x_i, y_i  - two's complement operands
//   ctrl_i    - control word {zx, nx, zy, ny, f, no}
//   res_o     - function result
//   zr_o      - result is all zeros
//   ng_o      - result sign bit
//   ov_o      - signed overflow of the internal add (only with MY_ALU_OVERFLOW_EN)
// Optional feature macro: MY_ALU_OVERFLOW_EN
module my_alu_comb
  import my_alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  alu_ctrl_t        ctrl_i,
  output logic [WIDTH-1:0] res_o,
  output logic             zr_o,
  output logic             ng_o
`ifdef MY_ALU_OVERFLOW_EN
  ,
  output logic             ov_o
`endif
);

  logic [WIDTH-1:0] xa;
  logic [WIDTH-1:0] xb;
  logic [WIDTH-1:0] ya;
  logic [WIDTH-1:0] yb;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] r;

  // Operand conditioning: zeroing happens before inversion, which is what
  // lets ~0 produce the all-ones constant used by the -1/+1 encodings.
  always_comb begin
    xa = ctrl_i.zx ? '0 : x_i;
    xb = ctrl_i.nx ? ~xa : xa;
    ya = ctrl_i.zy ? '0 : y_i;
    yb = ctrl_i.ny ? ~ya : ya;
  end

  // The add is WIDTH bits wide so the carry out is dropped.
  always_comb begin
    sum   = xb + yb;
    r     = ctrl_i.f ? sum : (xb & yb);
    res_o = ctrl_i.no ? ~r : r;
    zr_o  = (res_o == '0);
    ng_o  = res_o[WIDTH-1];
  end

`ifdef MY_ALU_OVERFLOW_EN
  // Overflow refers to xb+yb before the optional output inversion.
  always_comb begin
    ov_o = ctrl_i.f & (xb[WIDTH-1] == yb[WIDTH-1]) & (sum[WIDTH-1] != xb[WIDTH-1]);
  end
`endif

endmodule

// File: rtl/my_alu.sv
// my_alu
// Registered Hack-style ALU with one cycle of latency.
// Ports:
//   clk, rst_n         - clock and asynchronous active-low reset
//   in_valid           - capture the operands/controls on this edge
//   x, y               - operands
//   zx nx zy ny f no   - function select bits
//   out, zr, ng        - registered result and status flags (held when idle)
//   out_valid          - out/zr/ng hold a result captured on the last edge
//   ov                 - registered signed overflow (only with MY_ALU_OVERFLOW_EN)
// Optional feature macro: MY_ALU_OVERFLOW_EN
module my_alu
  import my_alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             out_valid
`ifdef MY_ALU_OVERFLOW_EN
  ,
  output logic             ov
`endif
);

  alu_ctrl_t        ctrl;
  logic [WIDTH-1:0] res_d;
  logic             zr_d;
  logic             ng_d;
  logic [WIDTH-1:0] out_q;
  logic             zr_q;
  logic             ng_q;
  logic             valid_q;

  assign ctrl = '{zx: zx, nx: nx, zy: zy, ny: ny, f: f, no: no};

`ifdef MY_ALU_OVERFLOW_EN
  logic ov_d;
  logic ov_q;
`endif

  my_alu_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .x_i    (x),
    .y_i    (y),
    .ctrl_i (ctrl),
    .res_o  (res_d),
    .zr_o   (zr_d),
    .ng_o   (ng_d)
`ifdef MY_ALU_OVERFLOW_EN
    ,
    .ov_o   (ov_d)
`endif
  );

  // Result registers only load on in_valid so an idle cycle keeps the last
  // answer visible; the reset value zr=1 matches out=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      zr_q  <= 1'b1;
      ng_q  <= 1'b0;
    end else if (in_valid) begin
      out_q <= res_d;
      zr_q  <= zr_d;
      ng_q  <= ng_d;
    end
  end

  // out_valid is a one-cycle pulse per captured operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
    end
  end

`ifdef MY_ALU_OVERFLOW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q <= 1'b0;
    end else if (in_valid) begin
      ov_q <= ov_d;
    end
  end

  assign ov = ov_q;
`endif

  assign out       = out_q;
  assign zr        = zr_q;
  assign ng        = ng_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_my_alu.sv
// tb_my_alu
// Self-checking bench for my_alu (WIDTH=16). Expected results are pushed to a
// scoreboard queue when an operation is driven and popped when out_valid rises.
// Define MY_ALU_OVERFLOW_EN to also exercise the ov output.
module tb_my_alu;
  import my_alu_pkg::*;

  typedef struct packed {
    logic [15:0] res;
    logic        zr;
    logic        ng;
    logic        chkOv;
    logic        ov;
  } exp_t;

  typedef struct packed {
    alu_ctrl_t   c;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] res;
    logic        chkOv;
    logic        ov;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] x;
  logic [15:0] y;
  logic        zx, nx, zy, ny, f, no;
  logic [15:0] out;
  logic        zr;
  logic        ng;
  logic        out_valid;
  logic        ov;

  int   checks;
  int   failures;
  exp_t sb[$];
  exp_t last;

  my_alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .zx        (zx),
    .nx        (nx),
    .zy        (zy),
    .ny        (ny),
    .f         (f),
    .no        (no),
    .out       (out),
    .zr        (zr),
    .ng        (ng),
    .out_valid (out_valid)
`ifdef MY_ALU_OVERFLOW_EN
    ,
    .ov        (ov)
`endif
  );

`ifndef MY_ALU_OVERFLOW_EN
  assign ov = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(alu_ctrl_t c, logic [15:0] xv, logic [15:0] yv,
                                 logic [15:0] res, logic chkOv, logic ovv);
    vec_t v;
    v.c = c; v.x = xv; v.y = yv; v.res = res; v.chkOv = chkOv; v.ov = ovv;
    return v;
  endfunction

  // Drive one valid operation at the falling edge, record its expectation,
  // then step to just after the capturing rising edge.
  task automatic driveOp(input vec_t v);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    x = v.x;
    y = v.y;
    {zx, nx, zy, ny, f, no} = v.c;
    e.res = v.res; e.zr = (v.res == 16'h0000); e.ng = v.res[15];
    e.chkOv = v.chkOv; e.ov = v.ov;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t v;
    exp_t e;
    rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0;
    {zx, nx, zy, ny, f, no} = 6'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out !== 16'h0000 || zr !== 1'b1 || ng !== 1'b0 || out_valid !== 1'b0 || ov !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_init got out=%h zr=%b ng=%b v=%b ov=%b want 0000 1 0 0 0", out, zr, ng, out_valid, ov);
    end
    // First edge after deassertion captures an operation.
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; x = 16'h8234; y = 16'h0000;
    {zx, nx, zy, ny, f, no} = CTRL_X;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out !== 16'h8234 || zr !== 1'b0 || ng !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_first_edge got v=%b out=%h zr=%b ng=%b want 1 8234 0 1", out_valid, out, zr, ng);
    end
    // Asynchronous assertion mid-operation clears outputs before any edge.
    @(negedge clk);
    in_valid = 1'b1; x = 16'h1111; y = 16'h2222;
    {zx, nx, zy, ny, f, no} = CTRL_X_ADD_Y;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 16'h0000 || zr !== 1'b1 || ng !== 1'b0 || out_valid !== 1'b0 || ov !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_async got out=%h zr=%b ng=%b v=%b ov=%b want 0000 1 0 0 0", out, zr, ng, out_valid, ov);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out !== 16'h0000 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_discard got out=%h v=%b want 0000 0", out, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    sb.delete();
    v = mkVec(CTRL_ZERO, 0, 0, 0, 0, 0);
    e = '0;
    last = e;
    if (v.res != 0) $display("[TB] unexpected vector");
  endtask

  task automatic test_constants();
    vec_t tbl[$];
    exp_t e;
    tbl.push_back(mkVec(CTRL_ZERO,    16'hAAAA, 16'hF0F0, 16'h0000, 1'b0, 1'b0));
    tbl.push_back(mkVec(CTRL_ONE,     16'hAAAA, 16'hF0F0, 16'h0001, 1'b0, 1'b0));
    tbl.push_back(mkVec(CTRL_NEG_ONE, 16'hAAAA, 16'hF0F0, 16'hFFFF, 1'b0, 1'b0));
    foreach (tbl[i]) begin
      driveOp(tbl[i]);
      checks++;
      if (out_valid !== 1'b1) begin
        failures++; $display("[TB] FAIL const_valid[%0d] got %b want 1", i, out_valid);
      end else if (sb.size() == 0) begin
        failures++; $display("[TB] FAIL const_sb[%0d] got empty scoreboard want entry", i);
      end else begin
        e = sb.pop_front(); last = e;
        checks++;
        if (out !== e.res || zr !== e.zr || ng !== e.ng) begin
          failures++;
          $display("[TB] FAIL const[%0d] got out=%h zr=%b ng=%b want %h %b %b", i, out, zr, ng, e.res, e.zr, e.ng);
        end
      end
    end
  endtask

  task automatic test_arith();
    vec_t tbl[$];
    exp_t e;
    tbl.push_back(mkVec(CTRL_X_ADD_Y, 16'hAAAA, 16'hF0F0, 16'h9B9A, 1'b1, 1'b0));
    tbl.push_back(mkVec(CTRL_X_SUB_Y, 16'hAAAA, 16'hF0F0, 16'hB9BA, 1'b0, 1'b0));
    tbl.push_back(mkVec(CTRL_Y_SUB_X, 16'hAAAA, 16'hF0F0, 16'h4646, 1'b0, 1'b0));
    tbl.push_back(mkVec(CTRL_NEG_X,   16'hAAAA, 16'hF0F0, 16'h5556, 1'b0, 1'b0));
    tbl.push_back(mkVec(CTRL_X_DEC,   16'hAAAA, 16'hF0F0, 16'hAAA9, 1'b0, 1'b0));
    tbl.push_back(mkVec(CTRL_Y_INC,   16'hAAAA, 16'hF0F0, 16'hF0F1, 1'b0, 1'b0));
    tbl.push_back(mkVec(CTRL_NEG_Y,   16'hAAAA, 16'hF0F0, 16'h0F10, 1'b0, 1'b0));
    foreach (tbl[i]) begin
      driveOp(tbl[i]);
      checks++;
      if (out_valid !== 1'b1) begin
        failures++; $display("[TB] FAIL arith_valid[%0d] got %b want 1", i, out_valid);
      end else if (sb.size() == 0) begin
        failures++; $display("[TB] FAIL arith_sb[%0d] got empty scoreboard want entry", i);
      end else begin
        e = sb.pop_front(); last = e;
        checks++;
        if (out !== e.res || zr !== e.zr || ng !== e.ng) begin
          failures++;
          $display("[TB] FAIL arith[%0d] got out=%h zr=%b ng=%b want %h %b %b", i, out, zr, ng, e.res, e.zr, e.ng);
        end
      end
    end
  endtask

  task automatic test_logic();
    vec_t tbl[$];
    exp_t e;
    tbl.push_back(mkVec(CTRL_X_AND_Y, 16'hAAAA, 16'hF0F0, 16'hA0A0, 1'b1, 1'b0));
    tbl.push_back(mkVec(CTRL_X_OR_Y,  16'hAAAA, 16'hF0F0, 16'hFAFA, 1'b1, 1'b0));
    tbl.push_back(mkVec(CTRL_NOT_X,   16'hFFFF, 16'h1234, 16'h0000, 1'b0, 1'b0));
    tbl.push_back(mkVec(CTRL_X_INC,   16'hFFFF, 16'h1234, 16'h0000, 1'b0, 1'b0));
    tbl.push_back(mkVec(CTRL_Y,       16'hFFFF, 16'h8001, 16'h8001, 1'b0, 1'b0));
    foreach (tbl[i]) begin
      driveOp(tbl[i]);
      checks++;
      if (out_valid !== 1'b1) begin
        failures++; $display("[TB] FAIL logic_valid[%0d] got %b want 1", i, out_valid);
      end else if (sb.size() == 0) begin
        failures++; $display("[TB] FAIL logic_sb[%0d] got empty scoreboard want entry", i);
      end else begin
        e = sb.pop_front(); last = e;
        checks++;
        if (out !== e.res || zr !== e.zr || ng !== e.ng) begin
          failures++;
          $display("[TB] FAIL logic[%0d] got out=%h zr=%b ng=%b want %h %b %b", i, out, zr, ng, e.res, e.zr, e.ng);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t tbl[$];
    exp_t e;
    tbl.push_back(mkVec(CTRL_X_ADD_Y, 16'h1234, 16'h0F0F, 16'h2143, 1'b0, 1'b0));
    tbl.push_back(mkVec(CTRL_Y_DEC,   16'h1234, 16'h0000, 16'hFFFF, 1'b0, 1'b0));
    tbl.push_back(mkVec(CTRL_NOT_Y,   16'h1234, 16'h00FF, 16'hFF00, 1'b0, 1'b0));
    foreach (tbl[i]) begin
      driveOp(tbl[i]);
      checks++;
      if (out_valid !== 1'b1) begin
        failures++; $display("[TB] FAIL b2b_valid[%0d] got %b want 1", i, out_valid);
      end else if (sb.size() == 0) begin
        failures++; $display("[TB] FAIL b2b_sb[%0d] got empty scoreboard want entry", i);
      end else begin
        e = sb.pop_front(); last = e;
        checks++;
        if (out !== e.res || zr !== e.zr || ng !== e.ng) begin
          failures++;
          $display("[TB] FAIL b2b[%0d] got out=%h zr=%b ng=%b want %h %b %b", i, out, zr, ng, e.res, e.zr, e.ng);
        end
      end
    end
    // Idle cycles with churning inputs must leave the last result in place.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      x = 16'($urandom); y = 16'($urandom);
      {zx, nx, zy, ny, f, no} = 6'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || out !== last.res || zr !== last.zr || ng !== last.ng) begin
        failures++;
        $display("[TB] FAIL hold[%0d] got v=%b out=%h zr=%b ng=%b want 0 %h %b %b", k, out_valid, out, zr, ng, last.res, last.zr, last.ng);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("[TB] FAIL sb_drain got %0d entries want 0", sb.size());
    end
  endtask

`ifdef MY_ALU_OVERFLOW_EN
  task automatic test_overflow();
    vec_t tbl[$];
    exp_t e;
    tbl.push_back(mkVec(CTRL_X_ADD_Y, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b1));
    tbl.push_back(mkVec(CTRL_X_ADD_Y, 16'hAAAA, 16'hF0F0, 16'h9B9A, 1'b1, 1'b0));
    tbl.push_back(mkVec(CTRL_X_SUB_Y, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1));
    tbl.push_back(mkVec(CTRL_X_AND_Y, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0));
    foreach (tbl[i]) begin
      driveOp(tbl[i]);
      checks++;
      if (out_valid !== 1'b1) begin
        failures++; $display("[TB] FAIL ov_valid[%0d] got %b want 1", i, out_valid);
      end else if (sb.size() == 0) begin
        failures++; $display("[TB] FAIL ov_sb[%0d] got empty scoreboard want entry", i);
      end else begin
        e = sb.pop_front(); last = e;
        checks++;
        if (out !== e.res || zr !== e.zr || ng !== e.ng || ov !== e.ov) begin
          failures++;
          $display("[TB] FAIL ov[%0d] got out=%h zr=%b ng=%b ov=%b want %h %b %b %b", i, out, zr, ng, ov, e.res, e.zr, e.ng, e.ov);
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0; x = 16'h0000; y = 16'h0000;
    @(posedge clk);
    #1;
    checks++;
    if (ov !== last.ov || out !== last.res) begin
      failures++; $display("[TB] FAIL ov_hold got ov=%b out=%h want %b %h", ov, out, last.ov, last.res);
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_constants();
    test_arith();
    test_logic();
    test_back_to_back();
`ifdef MY_ALU_OVERFLOW_EN
    test_overflow();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
